// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus-state encoding and the fill byte sent when no transmit data is held.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WRITE     = 3'd3,
        WRITE_ACK = 3'd4,
        READ      = 3'd5,
        READ_ACK  = 3'd6
    } i2c_state_t;

    localparam logic [7:0] TX_FILL = 8'hFF;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for an asynchronous bus pin with a previous-sample register for edge detection.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, prev_q;

    // The idle bus level is high, so everything resets to 1 to avoid a false edge after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= din;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~prev_q;
    assign fall  = ~s2_q & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C slave without clock stretching: one address, byte writes to data_o, byte reads through a one-byte hold register.
module i2c_slave
    import i2c_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] addr,
    input  logic [7:0] data_i,
    input  logic       data_valid,
    output logic       dataReq,
    output logic [7:0] data_o,
    output logic       newData,
    output logic       busy,
    output logic       read_nwrite,
    input  logic       SCL,
    inout  wire        SDA
);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    i2c_sync_edge u_scl_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (SCL),
        .level (scl_level),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (SDA),
        .level (sda_level),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    i2c_state_t state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       byte_done_q, byte_done_d;
    logic       sda_low_q, sda_low_d;
    logic [7:0] data_o_q, data_o_d;
    logic       new_data_q, new_data_d;
    logic       rnw_q, rnw_d;
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] hold_byte_q, hold_byte_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       need_q, need_d;
    logic       nack_q, nack_d;

    logic       start_det, stop_det;
    logic [7:0] load_byte;
    logic [7:0] rx_byte;

    assign start_det = sda_fall & scl_level;
    assign stop_det  = sda_rise & scl_level;
    assign load_byte = hold_valid_q ? hold_byte_q : TX_FILL;
    assign rx_byte   = {shift_q, sda_level};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 7'd0;
            byte_done_q  <= 1'b0;
            sda_low_q    <= 1'b0;
            data_o_q     <= 8'h00;
            new_data_q   <= 1'b0;
            rnw_q        <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_byte_q  <= 8'h00;
            tx_shift_q   <= 8'h00;
            need_q       <= 1'b0;
            nack_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_done_q  <= byte_done_d;
            sda_low_q    <= sda_low_d;
            data_o_q     <= data_o_d;
            new_data_q   <= new_data_d;
            rnw_q        <= rnw_d;
            hold_valid_q <= hold_valid_d;
            hold_byte_q  <= hold_byte_d;
            tx_shift_q   <= tx_shift_d;
            need_q       <= need_d;
            nack_q       <= nack_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_done_d  = byte_done_q;
        sda_low_d    = sda_low_q;
        data_o_d     = data_o_q;
        new_data_d   = 1'b0;
        rnw_d        = rnw_q;
        hold_valid_d = hold_valid_q;
        hold_byte_d  = hold_byte_q;
        tx_shift_d   = tx_shift_q;
        need_d       = need_q;
        nack_d       = nack_q;

        if (need_q && data_valid && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_byte_d  = data_i;
            need_d       = 1'b0;
        end

        // Bus conditions override whatever data edge arrives in the same cycle.
        if (start_det) begin
            state_d      = ADDR;
            bit_cnt_d    = 3'd0;
            byte_done_d  = 1'b0;
            sda_low_d    = 1'b0;
            hold_valid_d = 1'b0;
            need_d       = 1'b0;
        end else if (stop_det) begin
            state_d     = IDLE;
            byte_done_d = 1'b0;
            sda_low_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (shift_q == addr) begin
                                rnw_d       = sda_level;
                                byte_done_d = 1'b1;
                                if (sda_level)
                                    need_d = ~hold_valid_d;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end else if (scl_fall && byte_done_q) begin
                        state_d     = ADDR_ACK;
                        sda_low_d   = 1'b1;
                        byte_done_d = 1'b0;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        if (rnw_q) begin
                            state_d    = READ;
                            tx_shift_d = {load_byte[6:0], 1'b0};
                            sda_low_d  = ~load_byte[7];
                            if (hold_valid_q)
                                hold_valid_d = 1'b0;
                        end else begin
                            state_d   = WRITE;
                            sda_low_d = 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            data_o_d    = rx_byte;
                            new_data_d  = 1'b1;
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        state_d     = WRITE_ACK;
                        sda_low_d   = 1'b1;
                        byte_done_d = 1'b0;
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        state_d   = WRITE;
                        sda_low_d = 1'b0;
                        bit_cnt_d = 3'd0;
                    end
                end
                READ: begin
                    if (scl_fall) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d   = READ_ACK;
                            sda_low_d = 1'b0;
                            need_d    = ~hold_valid_d;
                        end else begin
                            sda_low_d  = ~tx_shift_q[7];
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end
                    end
                end
                READ_ACK: begin
                    if (scl_rise) begin
                        nack_d = sda_level;
                    end else if (scl_fall) begin
                        if (!nack_q) begin
                            state_d    = READ;
                            bit_cnt_d  = 3'd0;
                            tx_shift_d = {load_byte[6:0], 1'b0};
                            sda_low_d  = ~load_byte[7];
                            if (hold_valid_q)
                                hold_valid_d = 1'b0;
                        end else begin
                            state_d   = IDLE;
                            sda_low_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign SDA         = sda_low_q ? 1'b0 : 1'bz;
    assign dataReq     = need_q & ~hold_valid_q;
    assign data_o      = data_o_q;
    assign newData     = new_data_q;
    assign busy        = (state_q != IDLE);
    assign read_nwrite = rnw_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bus-level bench for i2c_slave: bit-banged master, scoreboards for written bytes and read-back bytes.
module tb_i2c_slave;

    localparam int Q = 20;

    logic       clk;
    logic       rst;
    logic [6:0] addr;
    logic [7:0] dataIn;
    logic       dataValid;
    logic       dataReq;
    logic [7:0] dataOut;
    logic       newData;
    logic       busy;
    logic       readNwrite;
    logic       sclM;
    logic       sdaM;
    wire        sdaBus;

    int checks = 0;
    int errors = 0;
    int newDataCount = 0;
    logic sawLow = 1'b0;
    logic ack;
    logic [7:0] rdByte;

    logic [7:0] writeExpQ[$];
    logic [7:0] readExpQ[$];
    logic [7:0] supplyQ[$];

    pullup (sdaBus);
    assign sdaBus = sdaM ? 1'bz : 1'b0;

    i2c_slave dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .data_i      (dataIn),
        .data_valid  (dataValid),
        .dataReq     (dataReq),
        .data_o      (dataOut),
        .newData     (newData),
        .busy        (busy),
        .read_nwrite (readNwrite),
        .SCL         (sclM),
        .SDA         (sdaBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Holds both bus lines for a quarter bit period; every bus phase is built from this.
    task automatic applyStimulus(input logic sclVal, input logic sdaVal);
        sclM = sclVal;
        sdaM = sdaVal;
        repeat (Q) @(negedge clk);
    endtask

    task automatic busStart();
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic busRepStart();
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic busStop();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
    endtask

    task automatic writeBit(input logic b);
        applyStimulus(1'b0, b);
        applyStimulus(1'b1, b);
        applyStimulus(1'b1, b);
        applyStimulus(1'b0, b);
    endtask

    task automatic readBit(output logic b);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        b = sdaBus;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
    endtask

    task automatic writeByte(input logic [7:0] value, output logic ackBit);
        for (int i = 7; i >= 0; i--)
            writeBit(value[i]);
        readBit(ackBit);
    endtask

    task automatic readByte(input logic masterAck, input string tag);
        logic b;
        logic [7:0] value;
        logic [7:0] expected;
        value = 8'h00;
        for (int i = 0; i < 8; i++) begin
            readBit(b);
            value = {value[6:0], b};
        end
        writeBit(masterAck);
        if (readExpQ.size() == 0) begin
            checkOutput({tag, "_noexp"}, 32'd1, 32'd0);
        end else begin
            expected = readExpQ.pop_front();
            checkOutput(tag, {24'd0, value}, {24'd0, expected});
        end
    endtask

    // Written-byte scoreboard: each newData pulse pops the next expected byte.
    initial begin
        logic [7:0] expected;
        forever begin
            @(negedge clk);
            if (newData) begin
                newDataCount++;
                if (writeExpQ.size() == 0) begin
                    checkOutput("newData_spurious", 32'd1, 32'd0);
                end else begin
                    expected = writeExpQ.pop_front();
                    checkOutput("data_o", {24'd0, dataOut}, {24'd0, expected});
                end
            end
        end
    end

    // Transmit-data responder: offers the next queued byte while dataReq is high.
    initial begin
        dataValid = 1'b0;
        dataIn    = 8'h00;
        forever begin
            @(negedge clk);
            if (dataReq && !dataValid && supplyQ.size() != 0) begin
                dataIn    = supplyQ.pop_front();
                dataValid = 1'b1;
            end else begin
                dataValid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (sdaM && sdaBus === 1'b0)
                sawLow = 1'b1;
        end
    end

    initial begin
        rst  = 1'b1;
        addr = 7'h42;
        sclM = 1'b1;
        sdaM = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("rst_sda", {31'd0, sdaBus}, 32'd1);
        checkOutput("rst_data_o", {24'd0, dataOut}, 32'h00);
        checkOutput("rst_newData", {31'd0, newData}, 32'd0);
        checkOutput("rst_dataReq", {31'd0, dataReq}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_rnw", {31'd0, readNwrite}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] two-byte write");
        newDataCount = 0;
        busStart();
        writeByte({7'h42, 1'b0}, ack);
        checkOutput("w_addr_ack", {31'd0, ack}, 32'd0);
        checkOutput("w_busy", {31'd0, busy}, 32'd1);
        writeExpQ.push_back(8'hA5);
        writeByte(8'hA5, ack);
        checkOutput("w_byte1_ack", {31'd0, ack}, 32'd0);
        writeExpQ.push_back(8'h3C);
        writeByte(8'h3C, ack);
        checkOutput("w_byte2_ack", {31'd0, ack}, 32'd0);
        busStop();
        checkOutput("w_newData_count", newDataCount, 32'd2);
        checkOutput("w_data_o_final", {24'd0, dataOut}, 32'h3C);
        checkOutput("w_busy_after_stop", {31'd0, busy}, 32'd0);

        $display("[TB] two-byte read");
        busStart();
        supplyQ.push_back(8'h5A);  readExpQ.push_back(8'h5A);
        supplyQ.push_back(8'h81);  readExpQ.push_back(8'h81);
        writeByte({7'h42, 1'b1}, ack);
        checkOutput("r_addr_ack", {31'd0, ack}, 32'd0);
        checkOutput("r_rnw", {31'd0, readNwrite}, 32'd1);
        readByte(1'b0, "r_byte1");
        readByte(1'b1, "r_byte2");
        repeat (5) @(negedge clk);
        checkOutput("r_busy_after_nack", {31'd0, busy}, 32'd0);
        checkOutput("r_sda_after_nack", {31'd0, sdaBus}, 32'd1);
        busStop();

        $display("[TB] foreign address");
        newDataCount = 0;
        sawLow = 1'b0;
        busStart();
        writeByte({7'h43, 1'b0}, ack);
        checkOutput("x_addr_nack", {31'd0, ack}, 32'd1);
        checkOutput("x_busy", {31'd0, busy}, 32'd0);
        writeByte(8'h99, ack);
        busStop();
        checkOutput("x_sda_never_low", {31'd0, sawLow}, 32'd0);
        checkOutput("x_no_newData", newDataCount, 32'd0);

        $display("[TB] read with no data supplied");
        busStart();
        readExpQ.push_back(8'hFF);
        writeByte({7'h42, 1'b1}, ack);
        checkOutput("f_addr_ack", {31'd0, ack}, 32'd0);
        readByte(1'b1, "f_fill_byte");
        checkOutput("f_dataReq_high", {31'd0, dataReq}, 32'd1);
        busStop();

        $display("[TB] repeated start from write into read");
        busStart();
        writeByte({7'h42, 1'b0}, ack);
        writeExpQ.push_back(8'h77);
        writeByte(8'h77, ack);
        checkOutput("rs_write_ack", {31'd0, ack}, 32'd0);
        busRepStart();
        checkOutput("rs_busy", {31'd0, busy}, 32'd1);
        supplyQ.push_back(8'h9C);  readExpQ.push_back(8'h9C);
        writeByte({7'h42, 1'b1}, ack);
        checkOutput("rs_addr_ack", {31'd0, ack}, 32'd0);
        checkOutput("rs_rnw", {31'd0, readNwrite}, 32'd1);
        readByte(1'b1, "rs_read_byte");
        busStop();

        $display("[TB] reset during read");
        busStart();
        supplyQ.push_back(8'hAB);
        writeByte({7'h42, 1'b1}, ack);
        for (int i = 0; i < 3; i++)
            readBit(ack);
        applyStimulus(1'b0, 1'b1);
        checkOutput("rr_bit4_low", {31'd0, sdaBus}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rr_sda_released", {31'd0, sdaBus}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        busStop();
        busStart();
        writeByte({7'h42, 1'b0}, ack);
        checkOutput("rr_addr_ack", {31'd0, ack}, 32'd0);
        writeExpQ.push_back(8'h11);
        writeByte(8'h11, ack);
        busStop();
        checkOutput("rr_data_o", {24'd0, dataOut}, 32'h11);

        checkOutput("write_queue_drained", writeExpQ.size(), 32'd0);
        checkOutput("read_queue_drained", readExpQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
